// File: rtl/opo_lock_sequencer.sv
// Lock-acquisition sequencer for the OPO locking datapath: sweeps the phase increment in steps,
// measures the windowed mean |X| at each step, locks on threshold and re-acquires after loss.
module opo_lock_sequencer #(
  parameter int unsigned X_WIDTH      = 16,
  parameter int unsigned INC_WIDTH    = 32,
  parameter int unsigned WIN_LOG2     = 10,
  parameter int unsigned LOSS_WINDOWS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic signed [X_WIDTH-1:0]   x_in,
  input  logic        [INC_WIDTH-1:0] inc_start,
  input  logic        [INC_WIDTH-1:0] inc_step,
  input  logic        [INC_WIDTH-1:0] inc_stop,
  input  logic        [X_WIDTH-2:0]   threshold,
  output logic        [INC_WIDTH-1:0] inc_out,
  output logic                        sinc_out,
  output logic                        user_cntr_out,
  output logic                        locked,
  output logic                        fail,
  output logic        [2:0]           state_o,
  output logic        [X_WIDTH-2:0]   mean_o
);

  localparam int unsigned MagW  = X_WIDTH - 1;
  localparam int unsigned AccW  = MagW + WIN_LOG2;
  localparam int unsigned MissW = $clog2(LOSS_WINDOWS + 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSync   = 3'd1,
    StDwell  = 3'd2,
    StCheck  = 3'd3,
    StLocked = 3'd4,
    StFail   = 3'd5
  } state_e;

  state_e                state_q;
  logic [INC_WIDTH-1:0]  step_q;
  logic [INC_WIDTH-1:0]  stop_q;
  logic [MagW-1:0]       thr_q;
  logic [AccW-1:0]       acc_q;
  logic [WIN_LOG2-1:0]   win_cnt_q;
  logic [MissW-1:0]      miss_q;

  logic [MagW-1:0]       mag;
  logic [AccW-1:0]       acc_sum;
  logic                  win_last;
  logic [MagW-1:0]       check_mean;
  logic [MagW-1:0]       lock_mean;
  logic [INC_WIDTH:0]    inc_next;
  logic                  step_bad;
  logic [MissW-1:0]      miss_inc;

  // Saturating magnitude: the most negative input maps to the largest positive value.
  always_comb begin
    mag = x_in[MagW-1:0];
    if (x_in[X_WIDTH-1]) begin
      if (x_in[MagW-1:0] == '0) begin
        mag = '1;
      end else begin
        mag = ~x_in[MagW-1:0] + MagW'(1);
      end
    end
  end

  assign acc_sum    = acc_q + AccW'(mag);
  assign win_last   = (win_cnt_q == '1);
  assign check_mean = acc_q[AccW-1:WIN_LOG2];
  assign lock_mean  = acc_sum[AccW-1:WIN_LOG2];
  assign inc_next   = {1'b0, inc_out} + {1'b0, step_q};
  assign step_bad   = (step_q == '0) || (inc_next > {1'b0, stop_q});
  assign miss_inc   = miss_q + MissW'(1);
  assign state_o    = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      inc_out       <= '0;
      sinc_out      <= 1'b0;
      user_cntr_out <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
      mean_o        <= '0;
      step_q        <= '0;
      stop_q        <= '0;
      thr_q         <= '0;
      acc_q         <= '0;
      win_cnt_q     <= '0;
      miss_q        <= '0;
    end else if (!enable) begin
      // Abort from any state; partial windows are dropped, mean_o is kept.
      state_q       <= StIdle;
      inc_out       <= '0;
      sinc_out      <= 1'b0;
      user_cntr_out <= 1'b0;
      locked        <= 1'b0;
      fail          <= 1'b0;
      acc_q         <= '0;
      win_cnt_q     <= '0;
      miss_q        <= '0;
    end else begin
      sinc_out <= 1'b0;
      case (state_q)
        StIdle: begin
          step_q    <= inc_step;
          stop_q    <= inc_stop;
          thr_q     <= threshold;
          inc_out   <= inc_start;
          acc_q     <= '0;
          win_cnt_q <= '0;
          miss_q    <= '0;
          sinc_out  <= 1'b1;
          state_q   <= StSync;
        end
        StSync: begin
          acc_q     <= '0;
          win_cnt_q <= '0;
          state_q   <= StDwell;
        end
        StDwell: begin
          acc_q     <= acc_sum;
          win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
          if (win_last) begin
            state_q <= StCheck;
          end
        end
        StCheck: begin
          mean_o    <= check_mean;
          acc_q     <= '0;
          win_cnt_q <= '0;
          if (check_mean >= thr_q) begin
            miss_q        <= '0;
            locked        <= 1'b1;
            user_cntr_out <= 1'b1;
            state_q       <= StLocked;
          end else if (step_bad) begin
            fail    <= 1'b1;
            state_q <= StFail;
          end else begin
            inc_out  <= inc_next[INC_WIDTH-1:0];
            sinc_out <= 1'b1;
            state_q  <= StSync;
          end
        end
        StLocked: begin
          win_cnt_q <= win_cnt_q + WIN_LOG2'(1);
          if (win_last) begin
            acc_q  <= '0;
            mean_o <= lock_mean;
            if (lock_mean >= thr_q) begin
              miss_q <= '0;
            end else if (miss_inc == MissW'(LOSS_WINDOWS)) begin
              // Sustained loss: re-acquire starting from the held increment.
              miss_q        <= '0;
              locked        <= 1'b0;
              user_cntr_out <= 1'b0;
              sinc_out      <= 1'b1;
              state_q       <= StSync;
            end else begin
              miss_q <= miss_inc;
            end
          end else begin
            acc_q <= acc_sum;
          end
        end
        StFail: begin
          state_q <= StFail;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opo_lock_sequencer.sv
// Scoreboard bench: a window-level reference model predicts every output change with its cycle,
// and a monitor pops and compares whenever the DUT outputs change.
module tb_opo_lock_sequencer;

  localparam int N    = 4;
  localparam int WL   = 2;
  localparam int LOSS = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic signed [15:0] x_in = '0;
  logic        [31:0] inc_start = '0;
  logic        [31:0] inc_step = '0;
  logic        [31:0] inc_stop = '0;
  logic        [14:0] threshold = '0;
  logic        [31:0] inc_out;
  logic               sinc_out;
  logic               user_cntr_out;
  logic               locked;
  logic               fail;
  logic        [2:0]  state_o;
  logic        [14:0] mean_o;

  opo_lock_sequencer #(
    .X_WIDTH     (16),
    .INC_WIDTH   (32),
    .WIN_LOG2    (WL),
    .LOSS_WINDOWS(LOSS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .x_in         (x_in),
    .inc_start    (inc_start),
    .inc_step     (inc_step),
    .inc_stop     (inc_stop),
    .threshold    (threshold),
    .inc_out      (inc_out),
    .sinc_out     (sinc_out),
    .user_cntr_out(user_cntr_out),
    .locked       (locked),
    .fail         (fail),
    .state_o      (state_o),
    .mean_o       (mean_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] inc;
    logic [14:0] mean;
    logic        sinc;
    logic        user;
    logic        lk;
    logic        fl;
  } tup_t;

  typedef struct {
    int   cyc;
    tup_t t;
  } ev_t;

  ev_t  sb[$];
  int   xs[0:511];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  tup_t prev_t;
  tup_t last_t;
  int   cur_base;
  int   cur_l;
  int   model_mean = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic tup_t mk(input logic [2:0] st, input logic [31:0] inc, input int mn,
                              input logic sinc, input logic user, input logic lk, input logic fl);
    tup_t t;
    t.st = st; t.inc = inc; t.mean = 15'(mn);
    t.sinc = sinc; t.user = user; t.lk = lk; t.fl = fl;
    return t;
  endfunction

  function automatic int sat_abs(input int x);
    if (x == -32768) return 32767;
    return (x < 0) ? -x : x;
  endfunction

  function automatic int wmean(input int first);
    int sum = 0;
    for (int i = 0; i < N; i++) sum += sat_abs(xs[first + i]);
    return sum / N;
  endfunction

  // Record an expected output tuple taking effect after edge edge_i of the current scenario.
  function automatic void ev(input int edge_i, input tup_t t);
    ev_t e;
    if (edge_i >= cur_l) return;
    if (t != last_t) begin
      e.cyc = cur_base + 1 + edge_i;
      e.t   = t;
      sb.push_back(e);
    end
    last_t = t;
  endfunction

  // Step-level model: a step is SYNC, N samples, CHECK; LOCKED runs back-to-back windows.
  task automatic model(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] so,
                       input int thr, input int kind);
    int s = 0;
    int e, w, miss;
    int mn = model_mean;
    logic [31:0] inc = st;
    logic [32:0] nxt;
    bit done = 1'b0;
    ev_t fin;
    last_t = mk(3'd0, 32'd0, model_mean, 1'b0, 1'b0, 1'b0, 1'b0);
    while (!done && s < cur_l) begin
      ev(s, mk(3'd1, inc, mn, 1'b1, 1'b0, 1'b0, 1'b0));
      ev(s + 1, mk(3'd2, inc, mn, 1'b0, 1'b0, 1'b0, 1'b0));
      ev(s + N + 1, mk(3'd3, inc, mn, 1'b0, 1'b0, 1'b0, 1'b0));
      e = s + N + 2;
      if (e >= cur_l) begin
        done = 1'b1;
      end else begin
        mn = wmean(s + 2);
        if (mn >= thr) begin
          ev(e, mk(3'd4, inc, mn, 1'b0, 1'b1, 1'b1, 1'b0));
          miss = 0;
          w = e + N;
          while (1'b1) begin
            if (w >= cur_l) begin
              done = 1'b1;
              break;
            end
            mn = wmean(w - N + 1);
            if (mn >= thr) miss = 0;
            else miss++;
            if (miss == LOSS) begin
              s = w;
              break;
            end
            ev(w, mk(3'd4, inc, mn, 1'b0, 1'b1, 1'b1, 1'b0));
            w += N;
          end
        end else begin
          nxt = {1'b0, inc} + {1'b0, sp};
          if (sp == 0 || nxt > {1'b0, so}) begin
            ev(e, mk(3'd5, inc, mn, 1'b0, 1'b0, 1'b0, 1'b1));
            done = 1'b1;
          end else begin
            inc = nxt[31:0];
            s = e;
          end
        end
      end
    end
    if (kind == 1) mn = 0;
    model_mean = mn;
    fin.cyc = cur_base + 1 + cur_l;
    fin.t   = mk(3'd0, 32'd0, mn, 1'b0, 1'b0, 1'b0, 1'b0);
    sb.push_back(fin);
  endtask

  // kind 0 ends the run by dropping enable before edge L, kind 1 by pulsing rst.
  task automatic run_scn(input logic [31:0] st, input logic [31:0] sp, input logic [31:0] so,
                         input int thr, input int l, input int kind);
    @(negedge clk);
    inc_start = st;
    inc_step  = sp;
    inc_stop  = so;
    threshold = 15'(thr);
    x_in      = 16'(xs[0]);
    cur_base  = cyc;
    cur_l     = l;
    model(st, sp, so, thr, kind);
    enable = 1'b1;
    for (int k = 0; k < l; k++) begin
      @(negedge clk);
      if (k == 0) begin
        inc_start = $urandom;
        inc_step  = $urandom;
        inc_stop  = $urandom;
        threshold = 15'($urandom);
      end
      x_in = 16'(xs[k + 1]);
    end
    if (kind == 1) begin
      rst    = 1'b1;
      enable = 1'b0;
    end else begin
      enable = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events never appeared, required 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    tup_t cur;
    ev_t  e;
    if (mon_en) begin
      cur = mk(state_o, inc_out, int'(mean_o), sinc_out, user_cntr_out, locked, fail);
      if (cur != prev_t) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cyc=%0d st=%0d inc=%0h mean=%0d sinc=%0b lk=%0b fl=%0b",
                   cyc, cur.st, cur.inc, cur.mean, cur.sinc, cur.lk, cur.fl);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.t != cur) begin
            fails++;
            $display({"FAIL event got cyc=%0d st=%0d inc=%0h mean=%0d sinc=%0b user=%0b lk=%0b ",
                      "fl=%0b required cyc=%0d st=%0d inc=%0h mean=%0d sinc=%0b user=%0b lk=%0b fl=%0b"},
                     cyc, cur.st, cur.inc, cur.mean, cur.sinc, cur.user, cur.lk, cur.fl,
                     e.cyc, e.t.st, e.t.inc, e.t.mean, e.t.sinc, e.t.user, e.t.lk, e.t.fl);
          end
        end
        prev_t = cur;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tup_t rt;
    int   l, v, seg;
    logic [31:0] st, sp, so;
    for (int i = 0; i < 512; i++) xs[i] = 0;
    repeat (3) @(negedge clk);
    rt = mk(state_o, inc_out, int'(mean_o), sinc_out, user_cntr_out, locked, fail);
    checks++;
    if (rt != mk(3'd0, 32'd0, 0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
      fails++;
      $display("FAIL reset_values got %h required 0", rt);
    end
    rst = 1'b0;
    prev_t = rt;
    mon_en = 1'b1;
    @(negedge clk);

    // Sweep to lock
    for (int k = 0; k < 512; k++) xs[k] = (k < 12) ? 500 : -1200;
    run_scn(32'd100, 32'd10, 32'd200, 1000, 30, 0);
    // Exhaustion
    for (int k = 0; k < 512; k++) xs[k] = 0;
    run_scn(32'd100, 32'd10, 32'd200, 1000, 75, 0);
    // Carry-out and zero step
    run_scn(32'hFFFF_FFF0, 32'h20, 32'hFFFF_FFFF, 1000, 10, 0);
    run_scn(32'd100, 32'd0, 32'd200, 1000, 10, 0);
    // Stop reached exactly
    run_scn(32'd100, 32'd50, 32'd200, 1000, 25, 0);
    // Loss with an interleaved passing window, then re-acquire
    for (int k = 0; k < 512; k++) begin
      if (k <= 6) xs[k] = 2000;
      else if (k <= 18) xs[k] = 0;
      else if (k <= 22) xs[k] = 2000;
      else if (k <= 38) xs[k] = 0;
      else xs[k] = 2000;
    end
    run_scn(32'd100, 32'd10, 32'd200, 1000, 60, 0);
    // Saturation
    for (int k = 0; k < 512; k++) xs[k] = -32768;
    run_scn(32'd5, 32'd1, 32'd9, 32767, 12, 0);
    // Abort on the second DWELL cycle
    for (int k = 0; k < 512; k++) xs[k] = 500;
    run_scn(32'd100, 32'd10, 32'd200, 1000, 3, 0);
    // Reset while locked
    for (int k = 0; k < 512; k++) xs[k] = (k < 12) ? 500 : -1200;
    run_scn(32'd100, 32'd10, 32'd200, 1000, 25, 1);

    for (int r = 0; r < 30; r++) begin
      seg = 0;
      v = 0;
      for (int k = 0; k < 512; k++) begin
        if (seg == 0) begin
          seg = $urandom_range(1, 12);
          v = ($urandom_range(0, 9) == 0) ? -32768 : int'($urandom_range(0, 8000)) - 4000;
        end
        xs[k] = v;
        seg--;
      end
      st = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FF00 + $urandom_range(0, 255) : $urandom;
      sp = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom_range(1, 1000);
      so = st + sp * $urandom_range(0, 4) + $urandom_range(0, 50);
      l  = $urandom_range(10, 120);
      run_scn(st, sp, so, $urandom_range(0, 4000), l, ($urandom_range(0, 4) == 0) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/opo_lock_sequencer.md
# opo_lock_sequencer

Lock-acquisition controller for the OPO locking datapath. It drives that datapath's phase-increment, resync and user-control inputs, sweeping the phase increment in discrete steps. At each step it measures the windowed mean magnitude of the demodulated X quadrature, declares lock when the mean reaches a threshold, then supervises the lock and re-acquires after sustained loss. It sits between the GPIO config registers and the locking datapath.

## Interface
- X_WIDTH, 16, width of signed demodulated input x_in
- INC_WIDTH, 32, width of phase increment values
- WIN_LOG2, 10, log2 of measurement window length N (N = 2^WIN_LOG2 cycles)
- LOSS_WINDOWS, 4, consecutive below-threshold windows in LOCKED that trigger re-acquisition (>=1)

- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- enable  in  1  level; high runs the sequencer, low forces IDLE
- x_in  in  X_WIDTH  signed X quadrature from the datapath, one sample per cycle
- inc_start  in  INC_WIDTH  first increment of the sweep (unsigned)
- inc_step  in  INC_WIDTH  increment added per failed step (unsigned)
- inc_stop  in  INC_WIDTH  last permitted increment (unsigned, inclusive)
- threshold  in  X_WIDTH-1  lock threshold on the window mean of |x_in|
- inc_out  out  INC_WIDTH  phase increment to the datapath
- sinc_out  out  1  one-cycle resync pulse to the datapath
- user_cntr_out  out  1  datapath user control; high only in LOCKED
- locked  out  1  high in LOCKED
- fail  out  1  high in FAIL
- state_o  out  3  current state encoding
- mean_o  out  X_WIDTH-1  mean |x_in| of the last completed window

## Operation
- States: IDLE=0, SYNC=1, DWELL=2, CHECK=3, LOCKED=4, FAIL=5. All outputs are registered.
- IDLE:
  - inc_out=0. Window counter, accumulator and miss counter are cleared.
  - When enable=1, latch inc_start, inc_step, inc_stop and threshold, then go to SYNC. Config input changes are ignored until the next IDLE.
- SYNC (1 cycle):
  - sinc_out=1.
  - On entry from IDLE, inc_out=inc_start latched. On entry from CHECK or LOCKED, inc_out is already set.
  - Next state is DWELL.
- DWELL (N cycles):
  - Each cycle, accumulate |x_in| into an accumulator of X_WIDTH-1+WIN_LOG2 bits.
  - |x_in| saturates: the most negative value maps to 2^(X_WIDTH-1)-1.
  - After the N-th sample, go to CHECK.
- CHECK (1 cycle):
  - mean_o = acc >> WIN_LOG2 (truncate). Clear the accumulator.
  - If mean_o >= threshold, go to LOCKED.
  - Otherwise compute next = inc_out + inc_step in INC_WIDTH+1 bits.
  - If inc_step=0, or next carries out, or next > inc_stop: go to FAIL with inc_out unchanged.
  - Otherwise inc_out=next and go to SYNC.
- LOCKED:
  - user_cntr_out=1 and locked=1. inc_out is held.
  - Back-to-back N-cycle windows run with no gap. At each window end, mean_o is updated.
  - If mean_o >= threshold, the miss counter is cleared. Otherwise it increments.
  - When the miss counter reaches LOSS_WINDOWS, clear it, deassert user_cntr_out/locked, and go to SYNC with inc_out held (re-acquire from the current increment).
- FAIL:
  - fail=1 and inc_out is held. Stays in FAIL until enable=0.
- enable=0 in any state: next state is IDLE, taking priority over all other transitions. Any partial window is discarded.
- rst has priority over enable.

## Timing
- Reset values:
  - inc_out=0, sinc_out=0, user_cntr_out=0, locked=0, fail=0, state_o=0, mean_o=0.
  - Accumulator, window counter and miss counter are 0.
- enable rises at cycle t: state_o=SYNC and sinc_out=1 at t+1, with inc_out=inc_start at t+1.
- A step costs N+2 cycles: SYNC 1, DWELL N, CHECK 1.
- DWELL samples x_in during the N cycles state_o=DWELL.
- CHECK outcome appears on state_o and inc_out the cycle after CHECK.
- sinc_out is never high for two consecutive cycles.
- In LOCKED, the window end falls every N cycles after entry; its first sample is on the first LOCKED cycle.
- Loss-to-SYNC latency: the cycle after the LOSS_WINDOWS-th failing window completes.
- A single passing window among misses resets the miss count (non-consecutive misses never unlock).
- inc_out == inc_stop exactly is a valid step.
- enable deasserted mid-DWELL: IDLE next cycle, and mean_o keeps its last value.
- rst mid-LOCKED: all reset values the next cycle.

## Test plan
- **Sweep to lock** (WIN_LOG2=2, inc_start=100, inc_step=10, inc_stop=200, threshold=1000): x_in=500 for the first two steps, then x_in=-1200.
  - Expect inc_out 100→110→120.
  - Expect three sinc_out pulses spaced 6 cycles apart.
  - Expect mean_o=1200 and LOCKED with user_cntr_out=1.
- **Exhaustion** (same setup, x_in=0):
  - Expect increments 100..200 (11 steps).
  - Expect FAIL after CHECK at 200, with inc_out=200 and fail=1.
  - enable=0 → IDLE, inc_out=0.
- **Overflow / zero step:**
  - inc_start=0xFFFFFFF0, inc_step=0x20, inc_stop=0xFFFFFFFF, x_in=0 → FAIL after the first CHECK with inc_out=0xFFFFFFF0.
  - inc_step=0 → FAIL after the first CHECK.
- **Loss and re-acquire** (LOSS_WINDOWS=4): from LOCKED, apply x_in=0 for 3 windows, then 1 passing window, then 4 windows.
  - Expect no unlock after the first 3 misses.
  - Expect SYNC the cycle after the 4th consecutive miss, with inc_out unchanged.
- **Saturation:** x_in=-32768 for a full window with threshold=32767 → mean_o=32767, LOCKED.
- **Abort/reset:**
  - enable=0 on the 2nd DWELL cycle → IDLE the next cycle.
  - rst asserted in LOCKED → all outputs at reset values the next cycle.
